// File: rtl/psi_filter_arb.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : psi_filter_arb
// Purpose  : Round-robin packet arbiter that shares the single psi_filter
//            payload input among N_CH section sources. A whole packet is
//            granted at a time and forwarded with one registered cycle of
//            latency. After each packet the arbiter waits for filter_done
//            (or a timeout), then inserts a guard gap before the next grant.
// Ports    : payload_clk_i / payload_rst_n_i  - clock, sync active-low reset
//            arb_enable_i, chan_mask_i         - grant enable, eligibility
//            req_valid/start/end/data_i, req_ready_o - per-channel streams
//            payload_out_valid/start/end/data_o      - to psi_filter
//            filter_done_i                      - search finished pulse
//            grant_idx_o, arb_busy_o            - arbitration status
//            err_count_o, timeout_count_o       - saturating counters
// Revision : 1.0 - initial release
// ============================================================================
module psi_filter_arb #(
  parameter int N_CH         = 4,
  parameter int DATA_W       = 32,
  parameter int MAX_WORDS    = 48,
  parameter int DONE_TIMEOUT = 256,
  parameter int GAP_CYCLES   = 2
) (
  input  logic                      payload_clk_i,
  input  logic                      payload_rst_n_i,
  input  logic                      arb_enable_i,
  input  logic [N_CH-1:0]           chan_mask_i,
  input  logic [N_CH-1:0]           req_valid_i,
  input  logic [N_CH-1:0]           req_start_i,
  input  logic [N_CH-1:0]           req_end_i,
  input  logic [N_CH*DATA_W-1:0]    req_data_i,
  output logic [N_CH-1:0]           req_ready_o,
  output logic                      payload_out_valid_o,
  output logic                      payload_out_start_o,
  output logic                      payload_out_end_o,
  output logic [DATA_W-1:0]         payload_out_data_o,
  input  logic                      filter_done_i,
  output logic [$clog2(N_CH)-1:0]   grant_idx_o,
  output logic                      arb_busy_o,
  output logic [15:0]               err_count_o,
  output logic [15:0]               timeout_count_o
);

  localparam int IDX_W  = $clog2(N_CH);
  localparam int WCNT_W = $clog2(MAX_WORDS + 1);
  localparam int TMAX   = (DONE_TIMEOUT > GAP_CYCLES) ? DONE_TIMEOUT : GAP_CYCLES;
  localparam int TMR_W  = $clog2(TMAX + 1);

  localparam logic [IDX_W-1:0]  C_LAST_CH   = IDX_W'(N_CH - 1);
  localparam logic [WCNT_W-1:0] C_LAST_WORD = WCNT_W'(MAX_WORDS - 1);
  localparam logic [TMR_W-1:0]  C_DONE_LAST = TMR_W'(DONE_TIMEOUT - 1);
  localparam logic [TMR_W-1:0]  C_GAP_LAST  = TMR_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FWD       = 3'd1,
    ST_DRAIN     = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GAP       = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic                out_valid_q, out_valid_d;
  logic                out_start_q, out_start_d;
  logic                out_end_q, out_end_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [15:0]         err_q, err_d;
  logic [15:0]         tout_q, tout_d;

  // Per-channel data lanes, so the granted lane can be selected by index.
  logic [DATA_W-1:0]   chan_data [N_CH];

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_unpack
    assign chan_data[gi] = req_data_i[gi*DATA_W +: DATA_W];
  end

  // Round-robin search state
  logic [N_CH-1:0]     elig;
  logic [N_CH-1:0]     discard;
  logic [3:0]          disc_cnt;
  logic                found;
  logic [IDX_W-1:0]    winner;
  logic [IDX_W-1:0]    cand_idx;
  int                  cand;

  // Granted-channel view
  logic                g_valid, g_start, g_end;
  logic [DATA_W-1:0]   g_data;

  logic [3:0]          err_inc;
  logic                tout_inc;
  logic [16:0]         err_sum;

  always_comb begin
    g_valid = req_valid_i[grant_q];
    g_start = req_start_i[grant_q];
    g_end   = req_end_i[grant_q];
    g_data  = chan_data[grant_q];
  end

  // Arbitration candidates: first eligible channel after the last grant.
  always_comb begin
    elig     = arb_enable_i ? (req_valid_i & req_start_i & chan_mask_i) : '0;
    discard  = req_valid_i & ~req_start_i & chan_mask_i;
    found    = 1'b0;
    winner   = grant_q;
    cand     = 0;
    cand_idx = '0;
    disc_cnt = '0;
    for (int k = 1; k <= N_CH; k++) begin
      cand     = (int'(grant_q) + k) % N_CH;
      cand_idx = IDX_W'(cand);
      if (!found && elig[cand_idx]) begin
        found  = 1'b1;
        winner = cand_idx;
      end
    end
    for (int i = 0; i < N_CH; i++) begin
      disc_cnt = disc_cnt + {3'b000, discard[i]};
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    wcnt_d      = wcnt_q;
    tmr_d       = tmr_q;
    out_valid_d = 1'b0;
    out_start_d = 1'b0;
    out_end_d   = 1'b0;
    out_data_d  = out_data_q;
    req_ready_o = '0;
    err_inc     = '0;
    tout_inc    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Stray mid-packet words from idle channels are swallowed and counted;
        // start words stay on the bus until their channel is granted.
        req_ready_o = discard;
        err_inc     = disc_cnt;
        if (found) begin
          grant_d = winner;
          wcnt_d  = '0;
          state_d = ST_FWD;
        end
      end

      ST_FWD: begin
        req_ready_o[grant_q] = 1'b1;
        if (g_valid) begin
          out_valid_d = 1'b1;
          out_data_d  = g_data;
          out_start_d = g_start && (wcnt_q == '0);
          wcnt_d      = wcnt_q + 1'b1;
          if (g_start && (wcnt_q != '0)) begin
            err_inc = err_inc + 4'd1;
          end
          if (g_end) begin
            out_end_d = 1'b1;
            tmr_d     = '0;
            state_d   = ST_WAIT_DONE;
          end else if (wcnt_q == C_LAST_WORD) begin
            // Oversized packet: close it at the filter entry size, drain rest.
            out_end_d = 1'b1;
            err_inc   = err_inc + 4'd1;
            state_d   = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        req_ready_o[grant_q] = 1'b1;
        if (g_valid && g_end) begin
          tmr_d   = '0;
          state_d = ST_WAIT_DONE;
        end
      end

      ST_WAIT_DONE: begin
        if (filter_done_i) begin
          tmr_d   = '0;
          state_d = ST_GAP;
        end else if (tmr_q == C_DONE_LAST) begin
          tmr_d    = '0;
          tout_inc = 1'b1;
          state_d  = ST_GAP;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      ST_GAP: begin
        if (tmr_q == C_GAP_LAST) begin
          tmr_d   = '0;
          state_d = ST_IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    err_sum = {1'b0, err_q} + {13'd0, err_inc};
    err_d   = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    tout_d  = (tout_inc && (tout_q != 16'hFFFF)) ? tout_q + 16'd1 : tout_q;
  end

  always_ff @(posedge payload_clk_i) begin
    if (!payload_rst_n_i) begin
      state_q     <= ST_IDLE;
      grant_q     <= C_LAST_CH;
      wcnt_q      <= '0;
      tmr_q       <= '0;
      out_valid_q <= 1'b0;
      out_start_q <= 1'b0;
      out_end_q   <= 1'b0;
      out_data_q  <= '0;
      err_q       <= '0;
      tout_q      <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      wcnt_q      <= wcnt_d;
      tmr_q       <= tmr_d;
      out_valid_q <= out_valid_d;
      out_start_q <= out_start_d;
      out_end_q   <= out_end_d;
      out_data_q  <= out_data_d;
      err_q       <= err_d;
      tout_q      <= tout_d;
    end
  end

  assign payload_out_valid_o = out_valid_q;
  assign payload_out_start_o = out_start_q;
  assign payload_out_end_o   = out_end_q;
  assign payload_out_data_o  = out_data_q;
  assign grant_idx_o         = grant_q;
  assign arb_busy_o          = (state_q != ST_IDLE);
  assign err_count_o         = err_q;
  assign timeout_count_o     = tout_q;

endmodule
`default_nettype wire

// File: tb/tb_psi_filter_arb.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : tb_psi_filter_arb
// Purpose  : Directed self-checking bench for psi_filter_arb. Per-channel
//            packet sources are modelled cycle by cycle; accepted input words
//            and emitted output words are logged and compared against
//            hand-derived expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_psi_filter_arb;

  localparam int N    = 4;
  localparam int W    = 32;
  localparam int MAXW = 48;
  localparam int TO   = 256;
  localparam int GAP  = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            arb_en;
  logic            fdone;
  logic [N-1:0]    mask, rv, rs, re, rdy;
  logic [N*W-1:0]  rd;
  logic            ov, os, oe;
  logic [W-1:0]    od;
  logic [1:0]      gidx;
  logic            busy;
  logic [15:0]     errc, toc;

  always #5 clk = ~clk;

  psi_filter_arb #(
    .N_CH(N), .DATA_W(W), .MAX_WORDS(MAXW), .DONE_TIMEOUT(TO), .GAP_CYCLES(GAP)
  ) dut (
    .payload_clk_i       (clk),
    .payload_rst_n_i     (rst_n),
    .arb_enable_i        (arb_en),
    .chan_mask_i         (mask),
    .req_valid_i         (rv),
    .req_start_i         (rs),
    .req_end_i           (re),
    .req_data_i          (rd),
    .req_ready_o         (rdy),
    .payload_out_valid_o (ov),
    .payload_out_start_o (os),
    .payload_out_end_o   (oe),
    .payload_out_data_o  (od),
    .filter_done_i       (fdone),
    .grant_idx_o         (gidx),
    .arb_busy_o          (busy),
    .err_count_o         (errc),
    .timeout_count_o     (toc)
  );

  typedef struct {
    int          ch;
    logic [31:0] d;
    bit          s;
    bit          e;
    int          cyc;
  } word_t;

  int    n_tests = 0;
  int    n_fail  = 0;

  // Source model state
  int    pk_left [N];
  int    plen    [N];
  int    w_idx   [N];
  int    pk_no   [N];

  int    cyc, done_delay, done_at, en_drop_at, total_acc;
  int    end_cyc, busy_fall_cyc, onehot_err;
  int    ready_seen [N];
  bit    prev_busy;
  word_t in_q[$];
  word_t out_q[$];
  int    grants[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_records();
    in_q.delete();
    out_q.delete();
    grants.delete();
    for (int c = 0; c < N; c++) ready_seen[c] = 0;
    onehot_err    = 0;
    total_acc     = 0;
    done_at       = -1;
    end_cyc       = 0;
    busy_fall_cyc = 0;
    prev_busy     = 1'b0;
  endtask

  task automatic load(input int ch, input int len, input int npk);
    pk_left[ch] = npk;
    plen[ch]    = len;
    w_idx[ch]   = 0;
    pk_no[ch]   = 0;
  endtask

  task automatic drive();
    for (int c = 0; c < N; c++) begin
      rv[c] = (pk_left[c] > 0);
      rs[c] = (pk_left[c] > 0) && (w_idx[c] == 0);
      re[c] = (pk_left[c] > 0) && (w_idx[c] == plen[c] - 1);
      rd[c*W +: W] = {8'(c), 8'(pk_no[c]), 16'(w_idx[c])};
    end
    fdone = (cyc == done_at);
  endtask

  task automatic sample();
    if ($countones(rdy) > 1) onehot_err++;
    for (int c = 0; c < N; c++) begin
      if (rdy[c]) ready_seen[c]++;
      if (rv[c] && rdy[c]) begin
        in_q.push_back('{c, rd[c*W +: W], rs[c], re[c], cyc});
        total_acc++;
        if (re[c]) begin
          end_cyc = cyc;
          if (done_delay >= 0) done_at = cyc + done_delay;
        end
        if (w_idx[c] == plen[c] - 1) begin
          w_idx[c] = 0;
          pk_left[c]--;
          pk_no[c]++;
        end else begin
          w_idx[c]++;
        end
      end
    end
    if (ov) out_q.push_back('{int'(gidx), od, os, oe, cyc});
    if (busy && !prev_busy) grants.push_back(int'(gidx));
    if (!busy && prev_busy) busy_fall_cyc = cyc;
    prev_busy = busy;
  endtask

  // Inputs change 1 time unit after the rising edge; everything is sampled
  // on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (en_drop_at > 0 && total_acc >= en_drop_at) arb_en = 1'b0;
    drive();
    @(negedge clk);
    sample();
  endtask

  function automatic bit srcs_empty();
    bit e;
    e = 1'b1;
    for (int c = 0; c < N; c++) if (mask[c] && pk_left[c] > 0) e = 1'b0;
    return e;
  endfunction

  task automatic run(input string tag, input int budget, input int stop_acc);
    bit fin;
    int n;
    fin = 1'b0;
    n   = 0;
    while (!fin && n < budget) begin
      step();
      n++;
      if (stop_acc > 0) fin = (total_acc >= stop_acc);
      else              fin = !busy && (!arb_en || srcs_empty());
    end
    check_eq({tag, "_finished"}, 64'(fin), 64'd1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    for (int c = 0; c < N; c++) load(c, 1, 0);
    done_delay = -1;
    en_drop_at = 0;
    arb_en     = 1'b1;
    mask       = '1;
    drive();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_records();
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int errs;
    int ends;
    rst_n = 1'b0; arb_en = 1'b0; fdone = 1'b0; mask = '0;
    rv = '0; rs = '0; re = '0; rd = '0;
    cyc = 0; done_delay = -1; en_drop_at = 0;
    for (int c = 0; c < N; c++) load(c, 1, 0);
    clear_records();

    // ---------------- Reset state ----------------
    do_reset();
    check_eq("rst_out_valid", 64'(ov), 64'd0);
    check_eq("rst_out_start", 64'(os), 64'd0);
    check_eq("rst_out_end",   64'(oe), 64'd0);
    check_eq("rst_out_data",  64'(od), 64'd0);
    check_eq("rst_ready",     64'(rdy), 64'd0);
    check_eq("rst_busy",      64'(busy), 64'd0);
    check_eq("rst_grant",     64'(gidx), 64'd3);
    check_eq("rst_err",       64'(errc), 64'd0);
    check_eq("rst_tout",      64'(toc), 64'd0);

    // ---------------- T1: 47-word packet on channel 0 ----------------
    do_reset();
    done_delay = 10;
    load(0, 47, 1);
    run("t1", 400, 0);
    check_eq("t1_in_words",  64'(in_q.size()),  64'd47);
    check_eq("t1_out_words", 64'(out_q.size()), 64'd47);
    if (out_q.size() == 47 && in_q.size() == 47) begin
      for (int i = 0; i < 47; i++) begin
        check_eq($sformatf("t1_data[%0d]", i),  64'(out_q[i].d), {32'd0, 8'd0, 8'd0, 16'(i)});
        check_eq($sformatf("t1_lag[%0d]", i),   64'(out_q[i].cyc - in_q[i].cyc), 64'd1);
        check_eq($sformatf("t1_start[%0d]", i), 64'(out_q[i].s), 64'(i == 0));
        check_eq($sformatf("t1_end[%0d]", i),   64'(out_q[i].e), 64'(i == 46));
      end
    end
    check_eq("t1_grant",      64'(gidx), 64'd0);
    // WAIT_DONE from end+1, done seen at end+10, then GAP cycles.
    check_eq("t1_busy_fall",  64'(busy_fall_cyc - end_cyc), 64'(10 + GAP + 1));
    check_eq("t1_err",        64'(errc), 64'd0);
    check_eq("t1_tout",       64'(toc), 64'd0);

    // ---------------- T2: all channels, round robin ----------------
    do_reset();
    done_delay = 3;
    for (int c = 0; c < N; c++) load(c, 4, 2);
    run("t2", 600, 0);
    check_eq("t2_ngrants", 64'(grants.size()), 64'd8);
    if (grants.size() == 8) begin
      for (int i = 0; i < 8; i++)
        check_eq($sformatf("t2_grant[%0d]", i), 64'(grants[i]), 64'(i % 4));
    end
    check_eq("t2_out_words", 64'(out_q.size()), 64'd32);
    errs = 0;
    for (int i = 0; i < out_q.size(); i++) begin
      if (out_q[i].d[31:24] != out_q[(i/4)*4].d[31:24]) errs++;
      if (out_q[i].d[15:0] != 16'(i % 4)) errs++;
    end
    check_eq("t2_interleave", 64'(errs), 64'd0);
    check_eq("t2_onehot",     64'(onehot_err), 64'd0);
    check_eq("t2_err",        64'(errc), 64'd0);

    // ---------------- T3: oversized packet on channel 2 ----------------
    do_reset();
    done_delay = 5;
    load(2, 60, 1);
    run("t3", 400, 0);
    check_eq("t3_in_words",  64'(in_q.size()),  64'd60);
    check_eq("t3_out_words", 64'(out_q.size()), 64'd48);
    ends = 0;
    for (int i = 0; i < out_q.size(); i++) if (out_q[i].e) ends++;
    check_eq("t3_end_count", 64'(ends), 64'd1);
    if (out_q.size() == 48) begin
      check_eq("t3_end_last",  64'(out_q[47].e), 64'd1);
      check_eq("t3_last_data", 64'(out_q[47].d), 64'h0000_0000_0200_002F);
      check_eq("t3_first_start", 64'(out_q[0].s), 64'd1);
    end
    check_eq("t3_err",   64'(errc), 64'd1);
    check_eq("t3_grant", 64'(gidx), 64'd2);

    // ---------------- T4: filter_done never arrives ----------------
    do_reset();
    done_delay = -1;
    load(1, 8, 1);
    run("t4", 600, 0);
    // WAIT_DONE occupies exactly TO cycles, then GAP.
    check_eq("t4_busy_fall", 64'(busy_fall_cyc - end_cyc), 64'(1 + TO + GAP));
    check_eq("t4_tout",      64'(toc), 64'd1);
    check_eq("t4_busy",      64'(busy), 64'd0);
    check_eq("t4_err",       64'(errc), 64'd0);

    // ---------------- T5: masked-out channel 2 ----------------
    do_reset();
    done_delay = 2;
    mask = 4'b1011;
    load(2, 4, 1);
    load(3, 4, 1);
    run("t5", 300, 0);
    repeat (10) step();
    check_eq("t5_ngrants", 64'(grants.size()), 64'd1);
    if (grants.size() >= 1) check_eq("t5_grant0", 64'(grants[0]), 64'd3);
    check_eq("t5_ch2_ready", 64'(ready_seen[2]), 64'd0);
    check_eq("t5_err",       64'(errc), 64'd0);

    // ---------------- T6: arb_enable dropped mid-packet ----------------
    do_reset();
    done_delay = 2;
    en_drop_at = 5;
    load(0, 20, 1);
    load(1, 4, 1);
    run("t6", 300, 0);
    repeat (20) step();
    check_eq("t6_out_words", 64'(out_q.size()), 64'd20);
    if (out_q.size() == 20) check_eq("t6_end_last", 64'(out_q[19].e), 64'd1);
    check_eq("t6_ngrants",   64'(grants.size()), 64'd1);
    check_eq("t6_ch1_ready", 64'(ready_seen[1]), 64'd0);
    check_eq("t6_busy",      64'(busy), 64'd0);

    // ---------------- T7: reset in the middle of a packet ----------------
    do_reset();
    done_delay = 2;
    load(0, 40, 1);
    run("t7", 200, 20);
    ends = 0;
    for (int i = 0; i < out_q.size(); i++) if (out_q[i].e) ends++;
    check_eq("t7_no_end_pre", 64'(ends), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    for (int c = 0; c < N; c++) load(c, 1, 0);
    drive();
    @(posedge clk);
    @(negedge clk);
    check_eq("t7_out_valid", 64'(ov), 64'd0);
    check_eq("t7_out_end",   64'(oe), 64'd0);
    check_eq("t7_out_data",  64'(od), 64'd0);
    check_eq("t7_busy",      64'(busy), 64'd0);
    check_eq("t7_grant",     64'(gidx), 64'd3);
    check_eq("t7_ready",     64'(rdy), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_records();
    load(0, 4, 1);
    load(1, 4, 1);
    run("t7b", 300, 0);
    check_eq("t7_ngrants", 64'(grants.size()), 64'd2);
    if (grants.size() >= 1) check_eq("t7_first_grant", 64'(grants[0]), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/psi_filter_arb.md
Name: psi_filter_arb

Overview:
- Round-robin packet arbiter that shares the single psi_filter payload input among N transport-stream section sources.
- Grants a whole packet at a time and forwards it with one cycle of registered latency.
- After each packet, holds off the next grant until the filter reports that its search is finished (or a timeout expires), then inserts a guard gap.
- Sits in the payload_clk domain, between the per-channel PID/section extractors and psi_filter.

Parameters:
- N_CH, 4, number of requesting channels (2..8).
- DATA_W, 32, payload word width; must match psi_filter PAYLOAD_DATA_WIDTH.
- MAX_WORDS, 48, maximum words per packet; equals the filter entry size of 192 bytes / 4.
- DONE_TIMEOUT, 256, maximum cycles spent waiting for filter_done.
- GAP_CYCLES, 2, idle cycles forced between packets; must be ≥1.

Ports:
- payload_clk, in, 1, single clock.
- payload_rst_n, in, 1, synchronous active-low reset.
- arb_enable, in, 1, 0 = no new grants; a packet already in flight completes normally.
- chan_mask, in, N_CH, 1 = channel is eligible for grant.
- req_valid, in, N_CH, per-channel word valid.
- req_start, in, N_CH, per-channel first word of packet.
- req_end, in, N_CH, per-channel last word of packet.
- req_data, in, N_CH*DATA_W, channel i occupies bits [i*DATA_W +: DATA_W].
- req_ready, out, N_CH, word accepted when valid & ready.
- payload_out_valid, out, 1, to psi_filter payload_in_valid.
- payload_out_start, out, 1, to psi_filter payload_in_start.
- payload_out_end, out, 1, to psi_filter payload_in_end.
- payload_out_data, out, DATA_W, to psi_filter payload_in_data.
- filter_done, in, 1, pulse from psi_filter: search_over or match write complete.
- grant_idx, out, clog2(N_CH), index of the current or last granted channel.
- arb_busy, out, 1, state ≠ IDLE.
- err_count, out, 16, saturating count of protocol errors.
- timeout_count, out, 16, saturating count of filter_done timeouts.

Behaviour:
- Reset (payload_rst_n = 0 at a clock edge):
  - State goes to IDLE.
  - All outputs 0.
  - grant_idx = N_CH-1, so channel 0 has first priority.
  - Counters 0.
  - Reset asserted mid-packet abandons the packet; no end word is emitted.
- States: IDLE, FWD, DRAIN, WAIT_DONE, GAP.
- IDLE:
  - Eligible channel = req_valid & req_start & chan_mask, with arb_enable = 1.
  - Search round-robin starting at grant_idx+1 with wrap-around; pick the first eligible channel.
  - Winner: grant_idx ← winner, go to FWD. The start word is not consumed in IDLE.
  - Any masked-in channel presenting valid without start gets req_ready = 1 in IDLE. The word is discarded and err_count increments once per discarded word.
  - Masked-out channels: ready = 0.
- FWD:
  - req_ready[grant_idx] = 1, combinational on state; all other ready bits = 0.
  - Each accepted word is registered to payload_out_* on the next cycle; out_valid pulses per word; gaps in req_valid pass through as out_valid = 0.
  - word_cnt counts accepted words.
  - req_end accepted: out_end = 1 on that word, go to WAIT_DONE.
  - word_cnt reaches MAX_WORDS without end: that 48th word is emitted with out_end forced to 1, err_count increments, go to DRAIN.
  - A start seen inside a packet (not on the first word) is forwarded with out_start = 0 and err_count increments.
- DRAIN: ready = 1 to the granted channel, words discarded until an accepted req_end; then go to WAIT_DONE.
- WAIT_DONE: all ready bits 0. Leave on filter_done = 1, or after DONE_TIMEOUT cycles (timeout_count increments); go to GAP.
- GAP: hold for GAP_CYCLES cycles, then go to IDLE.
- Simultaneous events:
  - filter_done on the same cycle as the end word is not counted; the wait begins the following cycle.
  - filter_done pulses seen outside WAIT_DONE are ignored.
- Counters saturate at 16'hFFFF.

Test Plan:
- Channel 0 sends 47 words with start on word 1 and end on word 47; filter_done arrives 10 cycles after end -> 47 output words, each lagging its input by 1 cycle; out_start on word 1, out_end on word 47; grant_idx = 0; next grant no earlier than 10 + GAP_CYCLES cycles after end.
- Channels 0-3 all request continuously -> grants follow the order 0,1,2,3,0; no packets interleave; ready is never high on two channels at once.
- Channel 2 sends 60 words with end on word 60 -> 48 words forwarded, out_end on word 48; 12 words drained; err_count = 1.
- filter_done never asserted -> WAIT_DONE lasts exactly 256 cycles; timeout_count = 1; arbiter then returns to IDLE.
- chan_mask = 4'b1011 with channel 2 requesting -> channel 2 never granted and its ready stays 0. arb_enable dropped mid-packet -> packet completes, then no further grants.
- payload_rst_n asserted at word 20 of a packet -> next cycle all outputs 0, state IDLE; after release, channel 0 is granted first.
